// File: rtl/word_ram_responder_if.sv
// Request/acknowledge bus between the ALU memory port (master) and the RAM responder (slave).
// A request level sampled while the responder is idle starts one access; the matching ack pulses for one cycle.
interface word_ram_responder_if;
    logic        readReq;
    logic        writeReq;
    logic [31:0] ramAddress;
    logic [31:0] ramOut;
    logic [31:0] ramValue;
    logic        readAck;
    logic        writeAck;
    logic        busError;

    modport master (
        output readReq, writeReq, ramAddress, ramOut,
        input  ramValue, readAck, writeAck, busError
    );

    modport slave (
        input  readReq, writeReq, ramAddress, ramOut,
        output ramValue, readAck, writeAck, busError
    );
endinterface

// File: rtl/word_ram_responder.sv
// Byte-addressed RAM serving 32-bit little-endian word reads/writes at any byte address,
// with optional wait states and a bus error for accesses running past the end of the RAM.
module word_ram_responder #(
    parameter int RAMSIZE     = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    word_ram_responder_if.slave  bus,
    output logic [1:0]           dbg_state
);

    localparam int          AW        = (RAMSIZE > 1) ? $clog2(RAMSIZE) : 1;
    localparam logic [31:0] LAST_ADDR = 32'(RAMSIZE - 4);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_write_q, is_write_d;
    logic [31:0] ram_value_q, ram_value_d;
    logic        read_ack_q, read_ack_d;
    logic        write_ack_q, write_ack_d;
    logic        bus_error_q, bus_error_d;

    logic [7:0]    mem_q [RAMSIZE];
    logic          in_range;
    logic          mem_we;
    logic [AW-1:0] idx0, idx1, idx2, idx3;
    logic [31:0]   rd_word;

    // Full 32-bit compare: addresses near 2^32 must not wrap back into the RAM.
    assign in_range = (addr_q <= LAST_ADDR);
    assign idx0     = addr_q[AW-1:0];
    assign idx1     = idx0 + AW'(1);
    assign idx2     = idx0 + AW'(2);
    assign idx3     = idx0 + AW'(3);
    assign rd_word  = {mem_q[idx3], mem_q[idx2], mem_q[idx1], mem_q[idx0]};
    assign mem_we   = (state_q == ST_ACCESS) && is_write_q && in_range;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_write_d  = is_write_q;
        ram_value_d = ram_value_q;
        read_ack_d  = 1'b0;
        write_ack_d = 1'b0;
        bus_error_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.readReq || bus.writeReq) begin
                    addr_d     = bus.ramAddress;
                    wdata_d    = bus.ramOut;
                    is_write_d = bus.writeReq;
                    if (WAIT_STATES > 0) begin
                        wait_cnt_d = WAIT_LOAD;
                        state_d    = ST_WAIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                bus_error_d = !in_range;
                if (is_write_q) begin
                    write_ack_d = 1'b1;
                end else begin
                    read_ack_d  = 1'b1;
                    ram_value_d = in_range ? rd_word : 32'd0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            is_write_q  <= 1'b0;
            ram_value_q <= 32'd0;
            read_ack_q  <= 1'b0;
            write_ack_q <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_write_q  <= is_write_d;
            ram_value_q <= ram_value_d;
            read_ack_q  <= read_ack_d;
            write_ack_q <= write_ack_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Storage is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx0] <= wdata_q[7:0];
            mem_q[idx1] <= wdata_q[15:8];
            mem_q[idx2] <= wdata_q[23:16];
            mem_q[idx3] <= wdata_q[31:24];
        end
    end

    assign bus.ramValue = ram_value_q;
    assign bus.readAck  = read_ack_q;
    assign bus.writeAck = write_ack_q;
    assign bus.busError = bus_error_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_word_ram_responder.sv
// Directed bench for word_ram_responder: a zero-wait instance (u0) and a three-wait-state instance (u1).
module tb_word_ram_responder;

    logic       clk;
    logic       reset;
    logic [1:0] dbg0, dbg1;
    int         tests_run;
    int         tests_failed;

    word_ram_responder_if bus0 ();
    word_ram_responder_if bus1 ();

    word_ram_responder #(.RAMSIZE(256), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset), .bus(bus0), .dbg_state(dbg0)
    );
    word_ram_responder #(.RAMSIZE(256), .WAIT_STATES(3)) u1 (
        .clk(clk), .reset(reset), .bus(bus1), .dbg_state(dbg1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input int inst, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        if (inst == 0) begin
            bus0.readReq = rd; bus0.writeReq = wr; bus0.ramAddress = addr; bus0.ramOut = data;
        end else begin
            bus1.readReq = rd; bus1.writeReq = wr; bus1.ramAddress = addr; bus1.ramOut = data;
        end
    endtask

    function automatic logic ack_seen(input int inst);
        if (inst == 0) return bus0.readAck || bus0.writeAck;
        return bus1.readAck || bus1.writeAck;
    endfunction

    // One access: request sampled at edge N, lat = edges from N to the ack, single = ack gone next cycle.
    task automatic access(input int inst, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          output int lat, output logic [31:0] val,
                          output logic rack, output logic wack, output logic berr,
                          output logic single);
        @(negedge clk);
        drive(inst, rd, wr, addr, data);
        @(posedge clk);
        @(negedge clk);
        drive(inst, 1'b0, 1'b0, 32'd0, 32'd0);
        lat = 0;
        while (!ack_seen(inst) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (inst == 0) begin
            val = bus0.ramValue; rack = bus0.readAck; wack = bus0.writeAck; berr = bus0.busError;
        end else begin
            val = bus1.ramValue; rack = bus1.readAck; wack = bus1.writeAck; berr = bus1.busError;
        end
        @(negedge clk);
        single = !ack_seen(inst);
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({bus0.ramValue, bus0.readAck, bus0.writeAck, bus0.busError, dbg0} !== 37'd0) begin
            tests_failed++;
            $display("FAIL reset_u0: got val=%h ra=%b wa=%b be=%b st=%0d, want all 0",
                     bus0.ramValue, bus0.readAck, bus0.writeAck, bus0.busError, dbg0);
        end
        tests_run++;
        if ({bus1.ramValue, bus1.readAck, bus1.writeAck, bus1.busError, dbg1} !== 37'd0) begin
            tests_failed++;
            $display("FAIL reset_u1: got val=%h ra=%b wa=%b be=%b st=%0d, want all 0",
                     bus1.ramValue, bus1.readAck, bus1.writeAck, bus1.busError, dbg1);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_rw();
        int lat; logic [31:0] v; logic ra, wa, be, s;
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, v, ra, wa, be, s);
        tests_run++;
        if ({lat, wa, ra, be, s} !== {32'd1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL write_basic: lat=%0d wa=%b ra=%b be=%b single=%b, want 1 1 0 0 1", lat, wa, ra, be, s);
        end
        tests_run++;
        if (v !== 32'd0) begin
            tests_failed++;
            $display("FAIL write_holds_value: ramValue=%h, want 00000000", v);
        end
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, v, ra, wa, be, s);
        tests_run++;
        if ({v, lat, ra, wa, be, s} !== {32'hDEADBEEF, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL read_basic: val=%h lat=%0d ra=%b wa=%b be=%b single=%b, want deadbeef 1 1 0 0 1",
                     v, lat, ra, wa, be, s);
        end
        access(0, 1'b1, 1'b0, 32'h13, 32'h0, lat, v, ra, wa, be, s);
        tests_run++;
        if (v[7:0] !== 8'hDE) begin
            tests_failed++;
            $display("FAIL byte_0x13: got %h, want de", v[7:0]);
        end
    endtask

    task automatic test_unaligned();
        int lat; logic [31:0] v; logic ra, wa, be, s;
        access(0, 1'b0, 1'b1, 32'h1D, 32'hAA000000, lat, v, ra, wa, be, s);
        access(0, 1'b0, 1'b1, 32'h21, 32'h11223344, lat, v, ra, wa, be, s);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, lat, v, ra, wa, be, s);
        tests_run++;
        if (v !== 32'h223344AA) begin
            tests_failed++;
            $display("FAIL unaligned_read: got %h, want 223344aa", v);
        end
    endtask

    task automatic test_range();
        int lat; logic [31:0] v; logic ra, wa, be, s;
        access(0, 1'b0, 1'b1, 32'hFC, 32'h01020304, lat, v, ra, wa, be, s);
        access(0, 1'b1, 1'b0, 32'hFC, 32'h0, lat, v, ra, wa, be, s);
        tests_run++;
        if ({v, ra, be} !== {32'h01020304, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL range_last_word: val=%h ra=%b be=%b, want 01020304 1 0", v, ra, be);
        end
        access(0, 1'b1, 1'b0, 32'hFD, 32'h0, lat, v, ra, wa, be, s);
        tests_run++;
        if ({v, ra, be, s} !== {32'h0, 1'b1, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL range_read_fd: val=%h ra=%b be=%b single=%b, want 0 1 1 1", v, ra, be, s);
        end
        access(0, 1'b1, 1'b0, 32'h100000FC, 32'h0, lat, v, ra, wa, be, s);
        tests_run++;
        if ({v, ra, be} !== {32'h0, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL range_high_bits: val=%h ra=%b be=%b, want 0 1 1", v, ra, be);
        end
        access(0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h99999999, lat, v, ra, wa, be, s);
        tests_run++;
        if ({wa, ra, be, lat} !== {1'b1, 1'b0, 1'b1, 32'd1}) begin
            tests_failed++;
            $display("FAIL range_write_ffffffff: wa=%b ra=%b be=%b lat=%0d, want 1 0 1 1", wa, ra, be, lat);
        end
        access(0, 1'b0, 1'b1, 32'hFD, 32'h77777777, lat, v, ra, wa, be, s);
        access(0, 1'b1, 1'b0, 32'hFC, 32'h0, lat, v, ra, wa, be, s);
        tests_run++;
        if ({v, be} !== {32'h01020304, 1'b0}) begin
            tests_failed++;
            $display("FAIL range_ram_unchanged: val=%h be=%b, want 01020304 0", v, be);
        end
        access(0, 1'b1, 1'b0, 32'h00, 32'h0, lat, v, ra, wa, be, s);
        tests_run++;
        if (be !== 1'b0) begin
            tests_failed++;
            $display("FAIL range_addr_zero: be=%b, want 0", be);
        end
    endtask

    task automatic test_both_requests();
        int lat; logic [31:0] v; logic ra, wa, be, s;
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, v, ra, wa, be, s);
        access(0, 1'b1, 1'b1, 32'h30, 32'h5, lat, v, ra, wa, be, s);
        tests_run++;
        if ({wa, ra, v, s} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b1}) begin
            tests_failed++;
            $display("FAIL both_req_write_wins: wa=%b ra=%b val=%h single=%b, want 1 0 deadbeef 1", wa, ra, v, s);
        end
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, lat, v, ra, wa, be, s);
        tests_run++;
        if (v !== 32'h5) begin
            tests_failed++;
            $display("FAIL both_req_readback: got %h, want 00000005", v);
        end
    endtask

    task automatic test_wait_states();
        int lat; logic [31:0] v; logic ra, wa, be, s;
        int ack_k[$];
        access(1, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, lat, v, ra, wa, be, s);
        tests_run++;
        if ({lat, wa, s} !== {32'd4, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL ws3_write_latency: lat=%0d wa=%b single=%b, want 4 1 1", lat, wa, s);
        end
        // Hold a read request high: second acceptance only once the FSM is back in IDLE.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h40, 32'h0);
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus1.readAck) ack_k.push_back(k);
            if (k == 11) drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        repeat (8) @(negedge clk);
        tests_run++;
        if (ack_k.size() != 2) begin
            tests_failed++;
            $display("FAIL ws3_held_req_acks: got %0d acks, want 2", ack_k.size());
        end else begin
            tests_run++;
            if (ack_k[0] != 4 || ack_k[1] != 10) begin
                tests_failed++;
                $display("FAIL ws3_held_req_timing: acks at %0d,%0d, want 4,10", ack_k[0], ack_k[1]);
            end
        end
        tests_run++;
        if (bus1.ramValue !== 32'hCAFEF00D) begin
            tests_failed++;
            $display("FAIL ws3_read_value: got %h, want cafef00d", bus1.ramValue);
        end
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [31:0] v; logic ra, wa, be, s;
        logic [1:0] st_before;
        access(1, 1'b0, 1'b1, 32'h50, 32'h12345678, lat, v, ra, wa, be, s);
        access(1, 1'b1, 1'b0, 32'h50, 32'h0, lat, v, ra, wa, be, s);
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 32'h50, 32'hAAAAAAAA);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        st_before = dbg1;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({st_before, bus1.ramValue, bus1.readAck, bus1.writeAck, bus1.busError, dbg1}
            !== {2'd1, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            tests_failed++;
            $display("FAIL reset_in_wait: st_before=%0d val=%h ra=%b wa=%b be=%b st=%0d, want 1 0 0 0 0 0",
                     st_before, bus1.ramValue, bus1.readAck, bus1.writeAck, bus1.busError, dbg1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        access(1, 1'b1, 1'b0, 32'h50, 32'h0, lat, v, ra, wa, be, s);
        tests_run++;
        if ({v, lat, ra, be} !== {32'h12345678, 32'd4, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL after_abort_read: val=%h lat=%0d ra=%b be=%b, want 12345678 4 1 0", v, lat, ra, be);
        end
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, lat, v, ra, wa, be, s);
        tests_run++;
        if (v !== 32'h5) begin
            tests_failed++;
            $display("FAIL ram_survives_reset: got %h, want 00000005", v);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        test_reset();
        test_basic_rw();
        test_unaligned();
        test_range();
        test_both_requests();
        test_wait_states();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
